// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame constants,
// common device command codes and the frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    BITS,
    ACK,
    WAITIDLE
  } state_t;

  localparam int NBITS_TX = 10;
  localparam int ACK_FALL = 11;

  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  localparam logic [7:0] CMD_RESET     = 8'hFF;

  // {odd parity, data}; shifted out LSB first
  function automatic logic [8:0] tx_frame(input logic [7:0] d);
    return {~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] data;
  logic       rdy;
  logic       done;
  logic       err;
  logic       rx_inh;

  modport master (output start, data, input rdy, done, err, rx_inh);
  modport slave  (input start, data, output rdy, done, err, rx_inh);
endinterface

// File: rtl/ps2_edge_sync.sv
// 2-FF synchroniser for a PS/2 pin plus a third stage for falling-edge detect.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic fall
);
  logic meta, sync_d;

  // idle PS/2 lines are high, so reset to 1 to avoid a spurious fall
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign fall = sync_d & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data LSB first, odd parity, stop, ACK.
// Optional device-clock watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = 3000,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2c_i,
  input  logic          ps2d_i,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [IW-1:0] INH_DATA = IW'(INHIBIT_CYC - 2);
  localparam logic [3:0]    STOP_IDX = 4'(NBITS_TX - 1);

  state_t        state;
  logic [IW-1:0] inh_cnt;
  logic [8:0]    shreg;
  logic [3:0]    bitcnt;
  logic          idle_seen;
  logic          rdy_q, done_q, err_q, rx_inh_q;
  logic          c_sync, c_fall, d_meta, d_sync;
  logic          wd_exp;

  ps2_edge_sync u_csync (
    .clk  (clk),
    .rst  (rst),
    .pin  (ps2c_i),
    .sync (c_sync),
    .fall (c_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      d_meta <= ps2d_i;
      d_sync <= d_meta;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
  logic [WW-1:0] wd;
  logic          watched;

  assign watched = (state == BITS) || (state == ACK) || (state == WAITIDLE);

  always_ff @(posedge clk) begin
    if (rst || !watched || c_fall) wd <= '0;
    else                           wd <= wd + 1'b1;
  end

  assign wd_exp = watched && !c_fall && (wd == WD_LAST);
`else
  assign wd_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_inh_q  <= 1'b0;
      ps2c_oe   <= 1'b0;
      ps2d_oe   <= 1'b0;
      inh_cnt   <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      idle_seen <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wd_exp) begin
        ps2c_oe  <= 1'b0;
        ps2d_oe  <= 1'b0;
        err_q    <= 1'b1;
        done_q   <= 1'b1;
        rdy_q    <= 1'b1;
        rx_inh_q <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            shreg    <= tx_frame(bus.data);
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            rx_inh_q <= 1'b1;
            ps2c_oe  <= 1'b1;
            inh_cnt  <= '0;
            state    <= INHIBIT;
          end
          INHIBIT: begin
            inh_cnt <= inh_cnt + 1'b1;
            // start bit goes low one cycle before the clock is released
            if (inh_cnt == INH_DATA) ps2d_oe <= 1'b1;
            if (inh_cnt == INH_LAST) begin
              ps2c_oe <= 1'b0;
              ps2d_oe <= 1'b1;
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            bitcnt    <= '0;
            idle_seen <= 1'b0;
            state     <= BITS;
          end
          BITS: if (c_fall) begin
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == STOP_IDX) begin
              ps2d_oe <= 1'b0;
              state   <= ACK;
            end else begin
              ps2d_oe <= ~shreg[0];
              shreg   <= {1'b0, shreg[8:1]};
            end
          end
          ACK: if (c_fall) begin
            err_q <= d_sync;
            state <= WAITIDLE;
          end
          WAITIDLE: begin
            if (c_sync && d_sync) begin
              idle_seen <= 1'b1;
              if (idle_seen) begin
                done_q   <= 1'b1;
                rdy_q    <= 1'b1;
                rx_inh_q <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              idle_seen <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rx_inh = rx_inh_q;
endmodule
